multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Multi-cycle control unit for the 8-bit microprocessor. Replaces single-cycle opcode decode with a Moore FSM that sequences FETCH/DECODE/EXEC/MEM/WB. Handshakes with memory via req/ready and has a bounded wait timeout. Drives the same datapath control set (branch, mem-to-reg, mem read/write, ALU op/src, reg write/dst) plus PC/IR write enables and fault status.

Parameters:
OP_W, 2, opcode width (>=2); class = op[OP_W-1:OP_W-2]: 00 ALU, 01 load, 10 store, 11 branch
TIMEOUT_W, 4, wait-counter width; fault after 2**TIMEOUT_W-1 cycles without mem_ready

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
op  in  OP_W  opcode from IR, valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request (FETCH, MEM load/store)
sigMemRead  out  1  read access (FETCH, load MEM)
sigMemWrite  out  1  write access (store MEM)
sigMemtoReg  out  1  WB source is memory (load WB)
sigRegWrite  out  1  register write (WB)
sigRegDst  out  1  dest = rd (ALU WB)
sigALUSrc  out  1  ALU B = immediate (load/store EXEC)
sigALUOp  out  2  00 add (addr), 01 sub (branch), 10 funct (ALU)
sigBranch  out  1  conditional PC write (branch EXEC)
pc_write  out  1  PC <= PC+1 (FETCH && mem_ready)
ir_write  out  1  IR load (FETCH && mem_ready)
instr_done  out  1  one-cycle pulse on instruction's final cycle
fault  out  1  sticky fault
fault_code  out  2  00 none, 01 timeout, 10 illegal op

Behaviour:
- Reset (reset==0): state=FETCH, class reg=00, wait counter=0, fault=0, fault_code=00; all outputs forced 0 combinationally while asserted.
- Outputs decode from state + latched class (Moore) except pc_write/ir_write/instr_done in FETCH/MEM, gated by mem_ready.
- FETCH: mem_req=1, sigMemRead=1. Hold until mem_ready; on mem_ready: pc_write=ir_write=1, -> DECODE.
- DECODE: latch class from op[OP_W-1:OP_W-2]; -> EXEC. No outputs.
- EXEC: ALU: sigALUOp=10, -> WB. Load/store: sigALUSrc=1, sigALUOp=00, -> MEM. Branch: sigALUOp=01, sigBranch=1, instr_done=1, -> FETCH.
- MEM: mem_req=1; load: sigMemRead=1; store: sigMemWrite=1. Hold until mem_ready; load -> WB; store -> FETCH with instr_done=1.
- WB: sigRegWrite=1; ALU: sigRegDst=1; load: sigMemtoReg=1; instr_done=1; -> FETCH.
- Latency (mem_ready immediate): ALU 4, load 5, store 4, branch 3 cycles.
- Wait counter: increments each cycle in FETCH/MEM with mem_ready=0; clears on mem_ready or state exit. Counter == 2**TIMEOUT_W-1 with mem_ready=0 -> FAULT, fault_code=01. mem_ready in that same cycle wins (normal completion).
- FAULT: all control outputs 0, fault=1; exit only by reset.
- Reset mid-access: asynchronous; mem_req drops immediately; no partial WB.

Optional Feature:
CTRL_ILLEGAL_OP_TRAP_EN: defined and OP_W>2: in DECODE, class 01/10/11 with op[OP_W-3:0]!=0 -> FAULT, fault_code=10, no EXEC outputs. Undefined (or OP_W==2): low bits ignored for those classes; fault_code 10 never produced.

Decomposition:
- Package ctrl_pkg: state enum (FETCH, DECODE, EXEC, MEM, WB, FAULT), class constants (CLS_ALU/LOAD/STORE/BRANCH), ALU-op constants (ALUOP_ADD/SUB/FUNCT), fault-code constants.
- One sub-module: ctrl_wait_timer (TIMEOUT_W counter, inputs count/clear, output expired).

Test Plan:
- Reset low 3 cycles, release, mem_ready=1: all outputs 0 during reset; cycle 1 after release mem_req=sigMemRead=pc_write=ir_write=1.
- OP_W=2, op=00, mem_ready=1: EXEC sigALUOp=10; WB sigRegWrite=sigRegDst=1, instr_done=1; back in FETCH at cycle 5.
- op=01, mem_ready low 3 cycles in MEM: MEM held 4 cycles, sigMemRead=1; WB sigMemtoReg=1; no fault.
- op=10 and op=11: store MEM sigMemWrite=1, sigALUSrc=1 in EXEC; branch EXEC sigBranch=1, sigALUOp=01, instr_done=1, 3 cycles total.
- TIMEOUT_W=4, mem_ready held 0 in FETCH: FAULT after 15 cycles, fault=1, fault_code=01, outputs 0 until reset; mem_ready=1 on cycle 15 instead -> no fault.
- With CTRL_ILLEGAL_OP_TRAP_EN, OP_W=4, op=4'b0101: DECODE -> FAULT, fault_code=10; without macro, executes as load.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } ctrl_state_e;

  typedef logic [1:0] ctrl_cls_t;

  localparam ctrl_cls_t CLS_ALU    = 2'b00;
  localparam ctrl_cls_t CLS_LOAD   = 2'b01;
  localparam ctrl_cls_t CLS_STORE  = 2'b10;
  localparam ctrl_cls_t CLS_BRANCH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: opcode, memory handshake, control set, status.
interface multicycle_control_if #(
  parameter int unsigned OP_W = 2
);
  logic [OP_W-1:0] op;
  logic            mem_ready;
  logic            mem_req;
  logic            sigMemRead;
  logic            sigMemWrite;
  logic            sigMemtoReg;
  logic            sigRegWrite;
  logic            sigRegDst;
  logic            sigALUSrc;
  logic [1:0]      sigALUOp;
  logic            sigBranch;
  logic            pc_write;
  logic            ir_write;
  logic            instr_done;
  logic            fault;
  logic [1:0]      fault_code;

  modport master (
    input  op, mem_ready,
    output mem_req, sigMemRead, sigMemWrite, sigMemtoReg, sigRegWrite,
           sigRegDst, sigALUSrc, sigALUOp, sigBranch, pc_write, ir_write,
           instr_done, fault, fault_code
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, sigMemRead, sigMemWrite, sigMemtoReg, sigRegWrite,
           sigRegDst, sigALUSrc, sigALUOp, sigBranch, pc_write, ir_write,
           instr_done, fault, fault_code
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Memory-wait counter; expired_o flags that the counter has reached all-ones.
module ctrl_wait_timer #(
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_i,
  input  logic clear_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '1);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait timeout.
// Optional: CTRL_ILLEGAL_OP_TRAP_EN traps non-zero low opcode bits for load/store/branch.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 2,
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  ctrl_state_e state_q;
  ctrl_cls_t   cls_q;
  logic        fault_q;
  logic [1:0]  fault_code_q;

  ctrl_cls_t   op_cls;
  logic        in_wait;
  logic        wait_count;
  logic        expired;
  logic        illegal_low;

  assign op_cls     = bus.op[OP_W-1 -: 2];
  assign in_wait    = (state_q == FETCH) || (state_q == MEM);
  assign wait_count = in_wait && !bus.mem_ready;

  ctrl_wait_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (reset),
    .count_i   (wait_count),
    .clear_i   (!wait_count),
    .expired_o (expired)
  );

`ifdef CTRL_ILLEGAL_OP_TRAP_EN
  if (OP_W > 2) begin : g_trap
    assign illegal_low = (op_cls != CLS_ALU) && (|bus.op[OP_W-3:0]);
  end else begin : g_no_trap
    assign illegal_low = 1'b0;
  end
`else
  logic unused_op_bits;
  assign unused_op_bits = ^bus.op;
  assign illegal_low    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      cls_q        <= CLS_ALU;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      case (state_q)
        FETCH: begin
          // mem_ready wins over an expiring counter in the same cycle
          if (bus.mem_ready) begin
            state_q <= DECODE;
          end else if (expired) begin
            state_q      <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FC_TIMEOUT;
          end
        end
        DECODE: begin
          cls_q <= op_cls;
          if (illegal_low) begin
            state_q      <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FC_ILLEGAL;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          case (cls_q)
            CLS_ALU:   state_q <= WB;
            CLS_LOAD,
            CLS_STORE: state_q <= MEM;
            default:   state_q <= FETCH;
          endcase
        end
        MEM: begin
          if (bus.mem_ready) begin
            state_q <= (cls_q == CLS_LOAD) ? WB : FETCH;
          end else if (expired) begin
            state_q      <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FC_TIMEOUT;
          end
        end
        WB:      state_q <= FETCH;
        FAULT:   state_q <= FAULT;
        default: state_q <= FAULT;
      endcase
    end
  end

  // Outputs are Moore decodes of state/class; only the completion strobes
  // look at mem_ready. Everything is forced low while reset is asserted.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.sigMemRead  = 1'b0;
    bus.sigMemWrite = 1'b0;
    bus.sigMemtoReg = 1'b0;
    bus.sigRegWrite = 1'b0;
    bus.sigRegDst   = 1'b0;
    bus.sigALUSrc   = 1'b0;
    bus.sigALUOp    = ALUOP_ADD;
    bus.sigBranch   = 1'b0;
    bus.pc_write    = 1'b0;
    bus.ir_write    = 1'b0;
    bus.instr_done  = 1'b0;
    bus.fault       = 1'b0;
    bus.fault_code  = FC_NONE;
    if (reset) begin
      bus.fault      = fault_q;
      bus.fault_code = fault_code_q;
      case (state_q)
        FETCH: begin
          bus.mem_req    = 1'b1;
          bus.sigMemRead = 1'b1;
          bus.pc_write   = bus.mem_ready;
          bus.ir_write   = bus.mem_ready;
        end
        EXEC: begin
          case (cls_q)
            CLS_ALU: bus.sigALUOp = ALUOP_FUNCT;
            CLS_LOAD,
            CLS_STORE: begin
              bus.sigALUSrc = 1'b1;
              bus.sigALUOp  = ALUOP_ADD;
            end
            default: begin
              bus.sigALUOp   = ALUOP_SUB;
              bus.sigBranch  = 1'b1;
              bus.instr_done = 1'b1;
            end
          endcase
        end
        MEM: begin
          bus.mem_req     = 1'b1;
          bus.sigMemRead  = (cls_q == CLS_LOAD);
          bus.sigMemWrite = (cls_q == CLS_STORE);
          bus.instr_done  = (cls_q == CLS_STORE) && bus.mem_ready;
        end
        WB: begin
          bus.sigRegWrite = 1'b1;
          bus.sigRegDst   = (cls_q == CLS_ALU);
          bus.sigMemtoReg = (cls_q == CLS_LOAD);
          bus.instr_done  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
